// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter: round-robin sharing of one external iterative sqrt unit among NUM_REQ requesters; optional WAIT watchdog under SQRT_ARB_TIMEOUT_EN
`timescale 1ns/1ps
module sqrt_arbiter #(
  parameter int WIDTH          = 32,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic [NUM_REQ-1:0]       resp_valid_o,
  output logic [WIDTH-1:0]         resp_data_o,
  input  logic [NUM_REQ-1:0]       resp_ready_i,
  output logic                     busy_o,
  output logic                     sqrt_go_o,
  output logic [WIDTH-1:0]         sqrt_in_o,
  output logic                     sqrt_reset_o,
  input  logic [WIDTH-1:0]         sqrt_out_i,
  input  logic                     sqrt_done_i
`ifdef SQRT_ARB_TIMEOUT_EN
  ,
  output logic                     timeout_err_o
`endif
);
  localparam int IDW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_q, rr_d, id_q, id_d, grant, scan;
  logic [WIDTH-1:0] sqrt_in_q, sqrt_in_d, resp_data_q, resp_data_d;
  logic             sqrt_reset_q, sqrt_reset_d;
  logic             any_req, timed_out;
  logic [WIDTH-1:0] req_arr [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_arr[g] = req_data_i[g*WIDTH +: WIDTH];
  end
  assign any_req = |req_valid_i;
  // Lowest offset from the rr pointer wins, so scan offsets from high to low.
  always_comb begin
    grant = rr_q;
    scan  = rr_q;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      scan = IDW'((int'(rr_q) + i) % NUM_REQ);
      if (req_valid_i[scan]) grant = scan;
    end
  end
`ifdef SQRT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_err_q;
  assign cnt_d         = state_q == WAIT ? cnt_q + CW'(1) : '0;
  assign timed_out     = state_q == WAIT && !sqrt_done_i && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  assign timeout_err_o = timeout_err_q;
  // Watchdog counts WAIT cycles; the error flag is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_q | timed_out;
    end
  end
`else
  assign timed_out = 1'b0;
`endif
  // Next-state logic: accept in IDLE, one-cycle go, wait for done, hold result until taken.
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    id_d         = id_q;
    sqrt_in_d    = sqrt_in_q;
    resp_data_d  = resp_data_q;
    sqrt_reset_d = timed_out;
    case (state_q)
      IDLE: if (any_req) begin
        state_d   = ISSUE;
        id_d      = grant;
        sqrt_in_d = req_arr[grant];
      end
      ISSUE: state_d = WAIT;
      WAIT: if (sqrt_done_i || timed_out) begin
        state_d     = RESP;
        resp_data_d = sqrt_done_i ? sqrt_out_i : '1;
      end
      RESP: if (resp_ready_i[id_q]) begin
        state_d = IDLE;
        rr_d    = id_q == IDW'(NUM_REQ - 1) ? '0 : id_q + IDW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  // State registers; the unit reset is held high through reset and for the first edge after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      id_q         <= '0;
      sqrt_in_q    <= '0;
      resp_data_q  <= '0;
      sqrt_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      id_q         <= id_d;
      sqrt_in_q    <= sqrt_in_d;
      resp_data_q  <= resp_data_d;
      sqrt_reset_q <= sqrt_reset_d;
    end
  end
  assign req_ready_o  = state_q == IDLE && any_req ? NUM_REQ'(1) << grant : '0;
  assign resp_valid_o = state_q == RESP ? NUM_REQ'(1) << id_q : '0;
  assign resp_data_o  = resp_data_q;
  assign busy_o       = state_q != IDLE;
  assign sqrt_go_o    = state_q == ISSUE;
  assign sqrt_in_o    = sqrt_in_q;
  assign sqrt_reset_o = sqrt_reset_q;
endmodule

// File: tb/tb_sqrt_arbiter.sv
// tb_sqrt_arbiter: randomized self-checking bench with a transaction-level arbitration and sqrt reference model
`timescale 1ns/1ps
module tb_sqrt_arbiter;
  localparam int W = 32, N = 4, T = 64, LAT = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] rv = '0, rr = '0;
  logic [N*W-1:0] rd = '0;
  logic [N-1:0] req_ready, resp_valid;
  logic [W-1:0] resp_data, sqrt_in, sqrt_out;
  logic busy, sqrt_go, sqrt_reset, sqrt_done;
  logic spur = 1'b0, done_en = 1'b1, unit_done = 1'b0, unit_busy = 1'b0;
  logic [W-1:0] unit_x = '0, unit_y = '0;
  int unit_cnt = 0;
  int checks = 0, failures = 0, mptr = 0;
`ifdef SQRT_ARB_TIMEOUT_EN
  logic timeout_err;
`endif

  sqrt_arbiter #(.WIDTH(W), .NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(rv), .req_data_i(rd), .req_ready_o(req_ready),
    .resp_valid_o(resp_valid), .resp_data_o(resp_data), .resp_ready_i(rr),
    .busy_o(busy), .sqrt_go_o(sqrt_go), .sqrt_in_o(sqrt_in), .sqrt_reset_o(sqrt_reset),
    .sqrt_out_i(sqrt_out), .sqrt_done_i(sqrt_done)
`ifdef SQRT_ARB_TIMEOUT_EN
    , .timeout_err_o(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] isqrt(input logic [W-1:0] x);
    longint r = 0, t;
    for (int b = W/2 - 1; b >= 0; b--) begin
      t = r + (longint'(1) << b);
      if (t * t <= longint'(x)) r = t;
    end
    return W'(r);
  endfunction

  function automatic int pick(input int p, input logic [N-1:0] m);
    for (int i = 0; i < N; i++) if (m[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  // Behavioural sqrt unit: LAT cycles after go it pulses done with the root.
  always @(posedge clk) begin
    unit_done <= 1'b0;
    if (sqrt_reset) unit_busy <= 1'b0;
    else if (sqrt_go) begin
      unit_busy <= 1'b1;
      unit_cnt  <= 1;
      unit_x    <= sqrt_in;
    end else if (unit_busy) begin
      if (unit_cnt == LAT) begin
        unit_busy <= 1'b0;
        unit_done <= done_en;
        unit_y    <= isqrt(unit_x);
      end else unit_cnt <= unit_cnt + 1;
    end
  end
  assign sqrt_out  = unit_y;
  assign sqrt_done = unit_done | spur;

  task automatic run_one(input int bp, input bit tmo);
    int g, n, lat;
    logic [W-1:0] v, e;
    logic [N-1:0] oh;
    #1;
    g   = pick(mptr, rv);
    oh  = N'(1) << g;
    v   = rd[g*W +: W];
    e   = tmo ? '1 : isqrt(v);
    lat = tmo ? T + 1 : LAT + 2;
    checks++;
    if (req_ready !== oh) begin failures++; $display("FAIL grant: req_ready=%b expected %b", req_ready, oh); end
    @(negedge clk); rv[g] = 1'b0; #1;
    checks++;
    if (sqrt_go !== 1'b1 || sqrt_in !== v || busy !== 1'b1 || req_ready !== '0)
      begin failures++; $display("FAIL issue: go=%b in=%h busy=%b rdy=%b expected go=1 in=%h busy=1 rdy=0", sqrt_go, sqrt_in, busy, req_ready, v); end
    @(negedge clk); #1;
    checks++;
    if (sqrt_go !== 1'b0 || req_ready !== '0) begin failures++; $display("FAIL go_pulse: go=%b rdy=%b expected 0 0", sqrt_go, req_ready); end
    n = 1;
    while (resp_valid === '0 && n < 200) begin @(negedge clk); #1; n++; end
    checks++;
    if (resp_valid !== oh || resp_data !== e || n != lat)
      begin failures++; $display("FAIL resp: valid=%b data=%h lat=%0d expected %b %h %0d", resp_valid, resp_data, n, oh, e, lat); end
    checks++;
    if (sqrt_reset !== tmo) begin failures++; $display("FAIL unit_reset: sqrt_reset=%b expected %b", sqrt_reset, tmo); end
    repeat (bp) begin
      rr = N'($urandom) & ~oh;
      @(negedge clk); #1;
      checks++;
      if (resp_valid !== oh || resp_data !== e || req_ready !== '0 || sqrt_go !== 1'b0)
        begin failures++; $display("FAIL backpressure: valid=%b data=%h rdy=%b go=%b expected %b %h 0 0", resp_valid, resp_data, req_ready, sqrt_go, oh, e); end
    end
    rr = oh | (N'($urandom) & ~oh);
    @(negedge clk); rr = '0; #1;
    checks++;
    if (resp_valid !== '0 || busy !== 1'b0) begin failures++; $display("FAIL release: valid=%b busy=%b expected 0 0", resp_valid, busy); end
    mptr = (g + 1) % N;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_data, sqrt_go, sqrt_in, busy, sqrt_reset} !== {8'h00, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1})
      begin failures++; $display("FAIL reset_vals: rdy=%b val=%b data=%h go=%b in=%h busy=%b srst=%b", req_ready, resp_valid, resp_data, sqrt_go, sqrt_in, busy, sqrt_reset); end
`ifdef SQRT_ARB_TIMEOUT_EN
    checks++;
    if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_terr: %b expected 0", timeout_err); end
`endif
    rst_n = 1'b1; #1;
    checks++;
    if (sqrt_reset !== 1'b1) begin failures++; $display("FAIL srst_hold: %b expected 1", sqrt_reset); end
    @(negedge clk); #1;
    checks++;
    if (sqrt_reset !== 1'b0) begin failures++; $display("FAIL srst_drop: %b expected 0", sqrt_reset); end
    mptr = 0;
  endtask

  task automatic test_all_four();
    rd = {32'd49, 32'd36, 32'd25, 32'd16};
    rv = 4'b1111;
    repeat (4) run_one(0, 1'b0);
  endtask

  task automatic test_single();
    rd[0 +: W] = 32'd144;
    rv = 4'b0001;
    run_one(0, 1'b0);
  endtask

  task automatic test_rr_order();
    rd[2*W +: W] = $urandom;
    rv = 4'b0100;
    run_one(0, 1'b0);
    rd[0 +: W] = $urandom;
    rd[3*W +: W] = $urandom;
    rv = 4'b1001;
    run_one(0, 1'b0);
    run_one(0, 1'b0);
  endtask

  task automatic test_edges();
    rd[0 +: W] = 32'd0;
    rd[W +: W] = 32'hFFFF_FFFF;
    rd[2*W +: W] = 32'd1;
    rv = 4'b0111;
    repeat (3) run_one(0, 1'b0);
  endtask

  task automatic test_backpressure();
    rd[W +: W] = $urandom;
    rd[2*W +: W] = $urandom;
    rv = 4'b0110;
    run_one(5, 1'b0);
    run_one(0, 1'b0);
  endtask

  task automatic test_spurious_done();
    rv = '0;
    @(negedge clk); spur = 1'b1;
    @(negedge clk); spur = 1'b0; #1;
    checks++;
    if (busy !== 1'b0 || resp_valid !== '0 || sqrt_go !== 1'b0)
      begin failures++; $display("FAIL spurious_done: busy=%b valid=%b go=%b expected 0", busy, resp_valid, sqrt_go); end
  endtask

  task automatic test_random();
    logic [N-1:0] add;
    repeat (40) begin
      add = N'($urandom) & ~rv;
      for (int i = 0; i < N; i++) if (add[i]) rd[i*W +: W] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 300)) : W'($urandom);
      rv = rv | add;
      if (rv == '0) begin
        rv[0] = 1'b1;
        rd[0 +: W] = $urandom;
      end
      run_one($urandom_range(0, 3), 1'b0);
    end
    while (rv != '0) run_one(0, 1'b0);
  endtask

  task automatic test_reset_mid();
    rd[$urandom_range(0, N-1)*W +: W] = $urandom;
    rv = 4'b0010;
    @(negedge clk); rv = '0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0; #1;
    checks++;
    if ({req_ready, resp_valid, resp_data, sqrt_go, sqrt_in, busy, sqrt_reset} !== {8'h00, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1})
      begin failures++; $display("FAIL reset_mid: rdy=%b val=%b data=%h go=%b in=%h busy=%b srst=%b", req_ready, resp_valid, resp_data, sqrt_go, sqrt_in, busy, sqrt_reset); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    mptr = 0;
    rd[0 +: W] = 32'd81;
    rd[3*W +: W] = $urandom;
    rv = 4'b1001;
    run_one(0, 1'b0);
    run_one(0, 1'b0);
  endtask

`ifdef SQRT_ARB_TIMEOUT_EN
  task automatic test_timeout();
    done_en = 1'b0;
    rd[W +: W] = $urandom;
    rv = 4'b0010;
    run_one(1, 1'b1);
    checks++;
    if (timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_err: %b expected 1", timeout_err); end
    done_en = 1'b1;
    rd[2*W +: W] = $urandom;
    rv = 4'b0100;
    run_one(0, 1'b0);
    checks++;
    if (timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_sticky: %b expected 1", timeout_err); end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_all_four();
    test_single();
    test_rr_order();
    test_edges();
    test_backpressure();
    test_spurious_done();
    test_random();
    test_reset_mid();
`ifdef SQRT_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sqrt_arbiter.md
Name: sqrt_arbiter

Overview:
- Round-robin controller that shares one iterative integer `sqrt` unit (go/done handshake) between NUM_REQ requesters.
- Accepts one request at a time, issues it to the unit, waits for `done`, then returns the result to the owning requester with valid/ready backpressure.
- Sits between datapath clients and a single `sqrt` instance, which is instantiated outside this block.

Parameters:
- WIDTH, 32: radicand/result width; must match the attached `sqrt` unit.
- NUM_REQ, 4: number of requesters, ≥2.
- TIMEOUT_CYCLES, 64: watchdog limit in WAIT; used only with SQRT_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- req_valid  in  NUM_REQ  per-requester request valid
- req_data  in  NUM_REQ*WIDTH  packed radicands; requester i uses bits [i*WIDTH +: WIDTH]
- req_ready  out  NUM_REQ  one-hot accept
- resp_valid  out  NUM_REQ  one-hot result valid
- resp_data  out  WIDTH  result, shared by all requesters
- resp_ready  in  NUM_REQ  per-requester result accept
- busy  out  1  high in any state except IDLE
- sqrt_go  out  1  single-cycle start to the unit
- sqrt_in  out  WIDTH  radicand to the unit
- sqrt_reset  out  1  active-high synchronous reset to the unit
- sqrt_out  in  WIDTH  unit result
- sqrt_done  in  1  unit done pulse

Behaviour:
- Reset values (reset low, asynchronous): state=IDLE, rr pointer=0, req_ready=0, resp_valid=0, resp_data=0, sqrt_go=0, sqrt_in=0, busy=0, sqrt_reset=1.
- sqrt_reset stays 1 for exactly one clk edge after reset deasserts, then 0.

FSM states: IDLE, ISSUE, WAIT, RESP.

IDLE:
- If any req_valid bit is set, grant goes to the first set bit scanning from rr pointer upward with wrap-around.
- req_ready[grant]=1 combinationally in this cycle only.
- On the accept edge: latch req_data slice into sqrt_in, latch grant id; go to ISSUE.
- If no req_valid bit is set, stay in IDLE.

ISSUE:
- sqrt_go=1 for exactly one cycle with sqrt_in stable; go to WAIT.
- sqrt_in stays held until the next accept.

WAIT:
- sqrt_go=0.
- On sqrt_done=1: register sqrt_out into resp_data, set resp_valid[id]; go to RESP.
- Minimum latency from accept to resp_valid is 2 cycles plus the unit latency (16 cycles for WIDTH=32).

RESP:
- Hold resp_valid[id] and resp_data stable until resp_ready[id]=1.
- On that edge: clear resp_valid, set rr pointer to (id+1) mod NUM_REQ; go to IDLE.
- resp_ready bits for other requesters are ignored.

Rules and boundary conditions:
- Request protocol: requesters hold req_valid and data until accepted. The arbiter never accepts while not in IDLE.
- Deasserting req_valid before accept is legal; that requester loses its turn without error.
- sqrt_done outside WAIT is ignored.
- Simultaneous requests: exactly one is granted per IDLE cycle. No requester waits more than NUM_REQ-1 other services.
- Back-to-back operation: a new accept is possible in the IDLE cycle directly after the RESP handshake, so the minimum turnaround is 1 cycle.
- Reset mid-operation: all state is cleared asynchronously and the in-flight result is discarded. The unit is reset via sqrt_reset.

Optional Feature:
- Macro: SQRT_ARB_TIMEOUT_EN.
- When defined:
  - A cycle counter runs in WAIT.
  - If TIMEOUT_CYCLES cycles elapse without sqrt_done, go to RESP with resp_data = all ones, and pulse sqrt_reset for one cycle.
  - A sticky output port `timeout_err` (1 bit, reset 0) is set; it clears only on reset.
- When undefined: no counter, no timeout_err port, and WAIT waits indefinitely.

Test Plan:
- Single request, requester 0, in=144 → req_ready[0] pulses once, sqrt_go pulses once with sqrt_in=144, resp_valid[0] with resp_data=12; busy low after resp_ready.
- All four req_valid high at once with in=16,25,36,49 → results returned in order 0,1,2,3 with 4,5,6,7; each sqrt_go exactly one cycle.
- After serving requester 2, requests from 0 and 3 present simultaneously → 3 is granted first, then 0.
- Edge values: in=0 → 0; in=0xFFFFFFFF → 65535; in=1 → 1.
- Backpressure: resp_ready[1] held low for 5 cycles while requester 2 requests →
  - resp_valid[1] and resp_data stay stable;
  - req_ready[2] stays 0 and no sqrt_go occurs;
  - requester 2 is accepted the cycle after the handshake.
- Reset asserted in WAIT → all outputs go to reset values immediately and sqrt_reset=1; after release, a request with in=81 returns 9. With SQRT_ARB_TIMEOUT_EN and sqrt_done tied low, the response arrives after TIMEOUT_CYCLES with resp_data=0xFFFFFFFF and timeout_err=1.
